// File: rtl/fft_r22sdf_twiddle_gen.sv
// fft_r22sdf_twiddle_gen: twiddle-factor generator for one R2^2 SDF stage pair, run on the 3x multiplier clock
// Ports:
//   clk_3x_i  3x clock, phase-locked to clk_i with coincident rising edges
//   rst_n     synchronous active-low reset
//   tog_i     clk_i-domain toggle, one transition per clk_i period
//   ctr_i     stage sample counter from the clk_i domain
//   ctr_o     ctr_i aligned with the twiddle outputs
//   w_re_o    twiddle real part, held for a whole clk_i period
//   w_im_o    twiddle imaginary part, held for a whole clk_i period
//   lock_o    phase tracker locked
module fft_r22sdf_twiddle_gen #(
  parameter int FFT_N         = 1024,
  parameter int NLOG2         = 10,
  parameter int STAGE_N       = 1024,
  parameter int TWIDDLE_WIDTH = 10
) (
  input  logic                            clk_3x_i,
  input  logic                            rst_n,
  input  logic                            tog_i,
  input  logic [NLOG2-1:0]                ctr_i,
  output logic [NLOG2-1:0]                ctr_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_im_o,
  output logic                            lock_o
);
  localparam int L  = $clog2(STAGE_N);
  localparam int QN = FFT_N / 4;
  localparam int AW = NLOG2 - 1;
  localparam int W  = TWIDDLE_WIDTH;

  // Quarter-wave cosine table evaluated at elaboration with a Q28 Taylor series
  function automatic logic signed [W-1:0] cos_q(input int i);
    longint x, x2, t, s;
    x  = 64'sd1686629713 * longint'(i) / longint'(FFT_N);
    x2 = (x * x) >>> 28;
    t  = 64'sd268435456;
    s  = t;
    for (int j = 1; j < 12; j++) begin
      t = -((t * x2) >>> 28) / longint'((2 * j - 1) * (2 * j));
      s = s + t;
    end
    return W'((s * ((64'sd1 <<< (W - 1)) - 64'sd1) + 64'sd134217728) >>> 28);
  endfunction

  logic signed [W-1:0] w_rom [QN+1];

  for (genvar i = 0; i <= QN; i++) begin : g_rom
    localparam logic signed [W-1:0] ROM_C = cos_q(i);
    assign w_rom[i] = ROM_C;
  end

  logic                r_tog_d, r_started, r_done, r_lock;
  logic [1:0]          r_phase;
  logic [2:0]          r_cnt;
  logic [NLOG2-1:0]    r_e, r_ctr_s, r_ctr_o;
  logic signed [W-1:0] r_a, r_b, r_w_re, r_w_im;

  logic                w_edge;
  logic [1:0]          w_phase, w_k, w_qd;
  logic [L-1:0]        w_m, w_n;
  logic [NLOG2-1:0]    w_e;
  logic [NLOG2-3:0]    w_r;
  logic [AW-1:0]       w_addr;
  logic signed [W-1:0] w_rd, w_re, w_im;

  // k is the bit-reversed quadrant index; n*k < STAGE_N so it fits in L bits before scaling
  always_comb begin
    w_edge  = tog_i ^ r_tog_d;
    w_phase = w_edge ? 2'd0 : (r_phase == 2'd2 ? 2'd2 : r_phase + 2'd1);
    w_m     = ctr_i[L-1:0];
    w_n     = w_m & L'(STAGE_N / 4 - 1);
    w_k     = {w_m[L-2], w_m[L-1]};
    w_e     = NLOG2'(w_n * L'(w_k)) << (NLOG2 - L);
    w_qd    = r_e[NLOG2-1 -: 2];
    w_r     = r_e[NLOG2-3:0];
    w_addr  = w_phase == 2'd2 ? AW'(QN) - AW'(w_r) : AW'(w_r);
    w_rd    = w_rom[w_addr];
    w_re    = w_qd == 2'd0 ? r_a : w_qd == 2'd1 ? -r_b : -r_a;
    w_im    = w_qd == 2'd0 ? -r_b : w_qd == 2'd1 ? -r_a : r_b;
  end

  // r_cnt counts cycles since the last edge; it resets saturated so the first edge never locks
  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      r_tog_d   <= 1'b0;
      r_phase   <= 2'd0;
      r_cnt     <= 3'd4;
      r_lock    <= 1'b0;
      r_started <= 1'b0;
      r_done    <= 1'b0;
      r_e       <= '0;
      r_ctr_s   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_w_re    <= '0;
      r_w_im    <= '0;
      r_ctr_o   <= '0;
    end else begin
      r_tog_d <= tog_i;
      r_phase <= w_phase;
      r_cnt   <= w_edge ? 3'd0 : (r_cnt == 3'd4 ? 3'd4 : r_cnt + 3'd1);
      r_lock  <= w_edge ? r_cnt == 3'd2 : r_lock && r_cnt < 3'd3;
      if (w_edge) begin
        r_e       <= w_e;
        r_ctr_s   <= ctr_i;
        r_started <= 1'b1;
        r_done    <= 1'b0;
        if (r_done) begin
          r_w_re  <= w_re;
          r_w_im  <= w_im;
          r_ctr_o <= r_ctr_s;
        end
      end else if (w_phase == 2'd1) begin
        r_a <= w_rd;
      end else begin
        r_b    <= w_rd;
        r_done <= r_started;
      end
    end
  end

  assign ctr_o  = r_ctr_o;
  assign w_re_o = r_w_re;
  assign w_im_o = r_w_im;
  assign lock_o = r_lock;
endmodule

// File: tb/tb_fft_r22sdf_twiddle_gen.sv
// tb_fft_r22sdf_twiddle_gen: directed scoreboard bench for the twiddle generator (STAGE_N 16 and 4 builds)
module tb_fft_r22sdf_twiddle_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tog = 1'b0;
  logic [3:0] ctr = 4'd0;
  logic [3:0] ctr_o, ctr4_o;
  logic signed [9:0] w_re, w_im, w4_re, w4_im;
  logic lock, lock4;

  typedef struct {
    logic v;
    logic [3:0] c;
    logic signed [9:0] re;
    logic signed [9:0] im;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_r22sdf_twiddle_gen #(.FFT_N(16), .NLOG2(4), .STAGE_N(16), .TWIDDLE_WIDTH(10)) dut (
    .clk_3x_i(clk), .rst_n(rst_n), .tog_i(tog), .ctr_i(ctr),
    .ctr_o(ctr_o), .w_re_o(w_re), .w_im_o(w_im), .lock_o(lock)
  );

  fft_r22sdf_twiddle_gen #(.FFT_N(16), .NLOG2(4), .STAGE_N(4), .TWIDDLE_WIDTH(10)) dut4 (
    .clk_3x_i(clk), .rst_n(rst_n), .tog_i(tog), .ctr_i(ctr),
    .ctr_o(ctr4_o), .w_re_o(w4_re), .w_im_o(w4_im), .lock_o(lock4)
  );

  // W = cos(2*pi*e/16) - j*sin(2*pi*e/16) at amplitude 511, e derived by hand per counter value
  function automatic exp_t ref_of(input logic [3:0] c);
    exp_t x;
    x.v = 1'b1;
    x.c = c;
    case (c)
      4'd5, 4'd10:  begin x.re = 10'sd361;  x.im = -10'sd361; end
      4'd6:         begin x.re = 10'sd0;    x.im = -10'sd511; end
      4'd7, 4'd14:  begin x.re = -10'sd361; x.im = -10'sd361; end
      4'd9:         begin x.re = 10'sd472;  x.im = -10'sd196; end
      4'd11, 4'd13: begin x.re = 10'sd196;  x.im = -10'sd472; end
      4'd15:        begin x.re = -10'sd472; x.im = 10'sd196;  end
      default:      begin x.re = 10'sd511;  x.im = 10'sd0;    end
    endcase
    return x;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic lk);
    chk("w_re", 32'(w_re), 32'(cur.re));
    chk("w_im", 32'(w_im), 32'(cur.im));
    chk("ctr_o", 32'(ctr_o), 32'(cur.c));
    chk("lock", 32'(lock), 32'(lk));
    chk("s4_w_re", 32'(w4_re), cur.v ? 32'sd511 : 32'sd0);
    chk("s4_w_im", 32'(w4_im), 32'sd0);
    chk("s4_ctr_o", 32'(ctr4_o), 32'(cur.c));
    chk("s4_lock", 32'(lock4), 32'(lk));
  endtask

  // One clk_i window of len clk_3x cycles starting with a tog edge; called just after a falling edge
  task automatic win(input int len, input logic [3:0] c, input bit push, input bit pop, input logic lk);
    for (int i = 1; i <= len; i++) begin
      if (i == 1) begin
        tog = ~tog;
        ctr = c;
      end
      @(posedge clk);
      if (i == 1 && pop && sb.size() != 0) cur = sb.pop_front();
      if (i == 1 && push) sb.push_back(ref_of(c));
      @(negedge clk);
      check_all(i >= 5 ? 1'b0 : lk);
    end
  endtask

  task automatic rst_cyc();
    rst_n = 1'b0;
    tog = 1'b0;
    @(posedge clk);
    sb.delete();
    cur = '{v: 1'b0, c: 4'd0, re: 10'sd0, im: 10'sd0};
    @(negedge clk);
    check_all(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    cur = '{v: 1'b0, c: 4'd0, re: 10'sd0, im: 10'sd0};
    @(negedge clk);
    rst_cyc();
    rst_cyc();
    win(3, 4'd0, 1, 0, 1'b0);
    win(3, 4'd1, 1, 1, 1'b1);
    win(3, 4'd2, 1, 1, 1'b1);
    win(3, 4'd3, 1, 1, 1'b1);
    win(3, 4'd5, 1, 1, 1'b1);
    win(3, 4'd14, 1, 1, 1'b1);
    win(3, 4'd15, 1, 1, 1'b1);
    win(3, 4'd9, 1, 1, 1'b1);
    win(3, 4'd6, 1, 1, 1'b1);
    win(3, 4'd11, 1, 1, 1'b1);
    win(2, 4'd13, 0, 1, 1'b1);
    win(3, 4'd10, 1, 0, 1'b0);
    win(3, 4'd12, 1, 1, 1'b1);
    win(3, 4'd7, 1, 1, 1'b1);
    win(9, 4'd5, 1, 1, 1'b1);
    win(3, 4'd14, 1, 1, 1'b0);
    win(3, 4'd9, 1, 1, 1'b1);
    win(1, 4'd15, 0, 1, 1'b1);
    rst_cyc();
    win(3, 4'd15, 1, 0, 1'b0);
    win(3, 4'd0, 1, 1, 1'b1);
    win(3, 4'd3, 0, 1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
